// File: rtl/apb_master_ctrl_if.sv
// Command/response handshake plus APB bus bundle for apb_master_ctrl.
// master = the APB initiator, slave = the requester/APB target side.
interface apb_master_ctrl_if #(
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32
);
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic                       cmd_write;
   logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
   logic [AMBA_WORD-1:0]       cmd_wdata;
   logic                       rsp_valid;
   logic [AMBA_WORD-1:0]       rsp_rdata;
   logic                       rsp_err;
   logic                       PSEL;
   logic                       PENABLE;
   logic                       PWRITE;
   logic [AMBA_ADDR_WIDTH-1:0] PADDR;
   logic [AMBA_WORD-1:0]       PWDATA;
   logic [AMBA_WORD-1:0]       PRDATA;
   logic                       PREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB initiator: turns single-word valid/ready commands into SETUP/ACCESS
// transfers and returns a one-cycle response pulse with read data / timeout status.
module apb_master_ctrl #(
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32,
   parameter int READ_LATE       = 1,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic               clk,
   input  logic               rst,
   apb_master_ctrl_if.master  bus
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMAX = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;

   assign bus.cmd_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         bus.PSEL      <= 1'b0;
         bus.PENABLE   <= 1'b0;
         bus.PWRITE    <= 1'b0;
         bus.PADDR     <= '0;
         bus.PWDATA    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.PADDR  <= {bus.cmd_addr[AMBA_ADDR_WIDTH-1:2], 2'b00};
                  bus.PWRITE <= bus.cmd_write;
                  if (bus.cmd_write)
                     bus.PWDATA <= bus.cmd_wdata;
                  bus.PSEL   <= 1'b1;
                  wait_cnt   <= '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               bus.PENABLE <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (bus.PREADY) begin
                  bus.PSEL    <= 1'b0;
                  bus.PENABLE <= 1'b0;
                  if (bus.PWRITE) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b0;
                     state         <= IDLE;
                  end else if (READ_LATE != 0) begin
                     // slave registers PRDATA, so sample it one cycle later
                     state <= CAPTURE;
                  end else begin
                     bus.rsp_rdata <= bus.PRDATA;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b0;
                     state         <= IDLE;
                  end
               end else if (TIMEOUT_CYCLES > 0) begin
                  if (wait_cnt == TMAX) begin
                     bus.PSEL      <= 1'b0;
                     bus.PENABLE   <= 1'b0;
                     bus.rsp_rdata <= '0;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + CW'(1);
                  end
               end
            end
            CAPTURE: begin
               bus.rsp_rdata <= bus.PRDATA;
               bus.rsp_valid <= 1'b1;
               bus.rsp_err   <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench: one READ_LATE=1 instance against a registered-PRDATA register
// selector model, one READ_LATE=0 instance with a hand-driven slave.
module tb_apb_master_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // shared requester stimulus, steered to one DUT by use_std
   logic        use_std   = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic        pready_s  = 1'b1;
   logic [31:0] prdata_s  = '0;
   logic [31:0] prdata_l  = '0;
   logic [31:0] regs [4];

   apb_master_ctrl_if #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32)) if_l ();
   apb_master_ctrl_if #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32)) if_s ();

   apb_master_ctrl #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .READ_LATE(1), .TIMEOUT_CYCLES(16))
      dut_late (.clk(clk), .rst(rst), .bus(if_l));
   apb_master_ctrl #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .READ_LATE(0), .TIMEOUT_CYCLES(16))
      dut_std (.clk(clk), .rst(rst), .bus(if_s));

   assign if_l.cmd_valid = cmd_valid & ~use_std;
   assign if_l.cmd_write = cmd_write;
   assign if_l.cmd_addr  = cmd_addr;
   assign if_l.cmd_wdata = cmd_wdata;
   assign if_l.PREADY    = 1'b1;
   assign if_l.PRDATA    = prdata_l;

   assign if_s.cmd_valid = cmd_valid & use_std;
   assign if_s.cmd_write = cmd_write;
   assign if_s.cmd_addr  = cmd_addr;
   assign if_s.cmd_wdata = cmd_wdata;
   assign if_s.PREADY    = pready_s;
   assign if_s.PRDATA    = prdata_s;

   // register selector with registered read data
   always @(posedge clk) begin
      if (if_l.PSEL && if_l.PENABLE && if_l.PREADY) begin
         if (if_l.PWRITE) regs[if_l.PADDR[3:2]] <= if_l.PWDATA;
         else             prdata_l <= regs[if_l.PADDR[3:2]];
      end
   end

   logic        m_ready, m_rv, m_err, m_psel, m_pen, m_pwr;
   logic [31:0] m_rdata, m_paddr, m_pwdata;
   assign m_ready  = use_std ? if_s.cmd_ready : if_l.cmd_ready;
   assign m_rv     = use_std ? if_s.rsp_valid : if_l.rsp_valid;
   assign m_err    = use_std ? if_s.rsp_err   : if_l.rsp_err;
   assign m_rdata  = use_std ? if_s.rsp_rdata : if_l.rsp_rdata;
   assign m_psel   = use_std ? if_s.PSEL      : if_l.PSEL;
   assign m_pen    = use_std ? if_s.PENABLE   : if_l.PENABLE;
   assign m_pwr    = use_std ? if_s.PWRITE    : if_l.PWRITE;
   assign m_paddr  = use_std ? if_s.PADDR     : if_l.PADDR;
   assign m_pwdata = use_std ? if_s.PWDATA    : if_l.PWDATA;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge of the first cycle after the accept edge
   task automatic accept(input logic w, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!m_ready && n < 50) begin @(negedge clk); n++; end
      check("accept_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // lat = cycle index after the accept edge in which rsp_valid is seen
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!m_rv && lat < 60) begin @(negedge clk); lat++; end
   endtask

   int lat, n_acc;

   initial begin
      // reset state, both instances
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         use_std = s[0];
         #1;
         check("rst_psel",  32'(m_psel),  32'd0);
         check("rst_pen",   32'(m_pen),   32'd0);
         check("rst_paddr", m_paddr,      32'd0);
         check("rst_pwdata", m_pwdata,    32'd0);
         check("rst_rv",    32'(m_rv),    32'd0);
         check("rst_rdata", m_rdata,      32'd0);
         check("rst_ready", 32'(m_ready), 32'd1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 1: write, zero wait states
      use_std = 1'b1; pready_s = 1'b1;
      accept(1'b1, 32'h4, 32'hDEADBEEF);
      check("t1_setup_psel", 32'(m_psel),  32'd1);
      check("t1_setup_pen",  32'(m_pen),   32'd0);
      check("t1_setup_addr", m_paddr,      32'h4);
      check("t1_setup_pwr",  32'(m_pwr),   32'd1);
      check("t1_setup_wd",   m_pwdata,     32'hDEADBEEF);
      check("t1_busy_ready", 32'(m_ready), 32'd0);
      @(negedge clk);
      check("t1_acc_psel", 32'(m_psel), 32'd1);
      check("t1_acc_pen",  32'(m_pen),  32'd1);
      check("t1_acc_addr", m_paddr,     32'h4);
      check("t1_acc_rv",   32'(m_rv),   32'd0);
      @(negedge clk);
      check("t1_rv",   32'(m_rv),   32'd1);
      check("t1_err",  32'(m_err),  32'd0);
      check("t1_psel", 32'(m_psel), 32'd0);
      @(negedge clk);
      check("t1_pulse", 32'(m_rv), 32'd0);

      // 2: READ_LATE=1 against the register selector
      use_std = 1'b0;
      accept(1'b1, 32'h0, 32'h12);
      wait_rsp(lat);
      check("t2_wr_lat", 32'(lat), 32'd3);
      accept(1'b1, 32'h8, 32'h20);
      wait_rsp(lat);
      accept(1'b0, 32'h0, 32'h0);
      wait_rsp(lat);
      check("t2_rd_lat",   32'(lat), 32'd4);
      check("t2_rd_data",  m_rdata,  32'h12);
      check("t2_rd_err",   32'(m_err), 32'd0);
      accept(1'b0, 32'h8, 32'h0);
      wait_rsp(lat);
      check("t2_rd2_lat",  32'(lat), 32'd4);
      check("t2_rd2_data", m_rdata,  32'h20);

      // 3: READ_LATE=0, three wait states
      use_std = 1'b1; pready_s = 1'b0; prdata_s = 32'hA5;
      accept(1'b0, 32'h8, 32'h0);
      check("t3_setup_pen", 32'(m_pen), 32'd0);
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         if (i == 5) pready_s = 1'b1;
         check("t3_acc_pen",  32'(m_pen), 32'd1);
         check("t3_acc_addr", m_paddr,    32'h8);
      end
      @(negedge clk);
      check("t3_rv",    32'(m_rv),  32'd1);
      check("t3_rdata", m_rdata,    32'hA5);
      check("t3_pen",   32'(m_pen), 32'd0);

      // 4: PREADY stuck low -> timeout abort, then recovery
      pready_s = 1'b0;
      accept(1'b0, 32'hC, 32'h0);
      lat = 1; n_acc = 0;
      while (!m_rv && lat < 60) begin
         @(negedge clk);
         lat++;
         if (m_pen) n_acc++;
      end
      check("t4_lat",    32'(lat),   32'd18);
      check("t4_access", 32'(n_acc), 32'd16);
      check("t4_err",    32'(m_err), 32'd1);
      check("t4_rdata",  m_rdata,    32'd0);
      check("t4_psel",   32'(m_psel), 32'd0);
      pready_s = 1'b1;
      accept(1'b1, 32'h0, 32'h5);
      wait_rsp(lat);
      check("t4_next_lat", 32'(lat),   32'd3);
      check("t4_next_err", 32'(m_err), 32'd0);

      // 5: asynchronous reset during ACCESS
      pready_s = 1'b0;
      accept(1'b1, 32'hC, 32'h99);
      @(negedge clk);
      check("t5_in_access", 32'(m_pen), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t5_psel",   32'(m_psel), 32'd0);
      check("t5_pen",    32'(m_pen),  32'd0);
      check("t5_pwr",    32'(m_pwr),  32'd0);
      check("t5_paddr",  m_paddr,     32'd0);
      check("t5_pwdata", m_pwdata,    32'd0);
      check("t5_rv",     32'(m_rv),   32'd0);
      repeat (2) begin
         @(negedge clk);
         check("t5_rv_rst", 32'(m_rv), 32'd0);
      end
      rst = 1'b1; pready_s = 1'b1;
      @(negedge clk);
      check("t5_rv_after", 32'(m_rv), 32'd0);
      accept(1'b1, 32'hC, 32'h77);
      wait_rsp(lat);
      check("t5_lat",    32'(lat),   32'd3);
      check("t5_err",    32'(m_err), 32'd0);
      check("t5_paddr_hold", m_paddr, 32'hC);
      check("t5_pwdata_hold", m_pwdata, 32'h77);

      // 6: command held through a busy write; unaligned read address
      prdata_s = 32'h3C;
      accept(1'b1, 32'h4, 32'h11);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h7; cmd_wdata = 32'hFFFFFFFF;
      check("t6_busy1", 32'(m_ready), 32'd0);
      @(negedge clk);
      check("t6_busy2", 32'(m_ready), 32'd0);
      @(negedge clk);
      check("t6_wr_rv",  32'(m_rv),    32'd1);
      check("t6_wr_err", 32'(m_err),   32'd0);
      check("t6_ready",  32'(m_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t6_rd_psel",  32'(m_psel), 32'd1);
      check("t6_rd_addr",  m_paddr,     32'h4);
      check("t6_rd_pwr",   32'(m_pwr),  32'd0);
      check("t6_rd_pwd",   m_pwdata,    32'h11);
      wait_rsp(lat);
      check("t6_rd_lat",   32'(lat), 32'd3);
      check("t6_rd_data",  m_rdata,  32'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
